prbs_stream_gen: RTL and testbench



---
 rtl/prbs_stream_gen_if.sv | 46 ++++
 rtl/prbs_stream_gen.sv | 278 +++++++++++++++++++++++++++
 tb/tb_prbs_stream_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_stream_gen_if.sv
// ----------------------------------------------------------------------------
// prbs_stream_gen_if
//
// Bundle of the configuration words written by the PRBS_driver register slave
// and the stream/status signals returned by the sequence engine.
//
// Signals:
//   cfg_ctrl   [31:0]          control word (enable/start/continuous/invert/poly)
//   cfg_seed   [31:0]          LFSR seed
//   cfg_len    [31:0]          bits per run (ignored in continuous mode)
//   cfg_div    [DIV_WIDTH-1:0] bit period minus one, in clocks
//   prbs_bit                   registered stream bit
//   bit_strobe                 one-cycle pulse when prbs_bit takes a new value
//   busy                       engine is loading or running
//   done                       sticky run-complete flag
//   bit_count  [31:0]          bits emitted since the last load
//   status     [31:0]          packed status word for register readback
//
// Modports:
//   master : register slave side, drives configuration, observes results
//   slave  : sequence engine side
// ----------------------------------------------------------------------------
interface prbs_stream_gen_if #(
    parameter int DIV_WIDTH = 16
);
    logic [31:0]          cfg_ctrl;
    logic [31:0]          cfg_seed;
    logic [31:0]          cfg_len;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 prbs_bit;
    logic                 bit_strobe;
    logic                 busy;
    logic                 done;
    logic [31:0]          bit_count;
    logic [31:0]          status;

    modport master (
        output cfg_ctrl, cfg_seed, cfg_len, cfg_div,
        input  prbs_bit, bit_strobe, busy, done, bit_count, status
    );

    modport slave (
        input  cfg_ctrl, cfg_seed, cfg_len, cfg_div,
        output prbs_bit, bit_strobe, busy, done, bit_count, status
    );
endinterface

// File: rtl/prbs_stream_gen.sv
// ----------------------------------------------------------------------------
// prbs_stream_gen
//
// Rate-divided pseudo-random bit stream generator for the memristor testboard
// drive path. A Fibonacci LFSR (PRBS7/9/15/23/31) held in a 31-bit register is
// stepped once every cfg_div+1 clocks while running; each step produces one
// output bit and a one-cycle strobe. Runs are either a fixed number of bits or
// continuous until enable is dropped.
//
// Ports:
//   ACLK      system clock
//   ARESETN   asynchronous active-low reset
//   bus       prbs_stream_gen_if.slave
//               in : cfg_ctrl, cfg_seed, cfg_len, cfg_div
//               out: prbs_bit, bit_strobe, busy, done, bit_count, status
//
// cfg_ctrl: [0] enable, [1] start (rising edge), [2] continuous, [3] invert,
//           [6:4] polynomial select (0:PRBS7 1:PRBS9 2:PRBS15 3:PRBS23
//           4:PRBS31, 5-7:PRBS7)
// status:   [0] busy, [1] done, [2] aborted, [6:4] latched polynomial select
// ----------------------------------------------------------------------------
module prbs_stream_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    prbs_stream_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Polynomial tables: active-bit mask, MSB index (N-1), tap index.
    // Selects 5-7 fall back to PRBS7.
    // ------------------------------------------------------------------
    function automatic logic [30:0] poly_mask(input logic [2:0] sel);
        case (sel)
            3'd1:    poly_mask = 31'h0000_01FF;
            3'd2:    poly_mask = 31'h0000_7FFF;
            3'd3:    poly_mask = 31'h007F_FFFF;
            3'd4:    poly_mask = 31'h7FFF_FFFF;
            default: poly_mask = 31'h0000_007F;
        endcase
    endfunction

    function automatic logic [4:0] poly_msb(input logic [2:0] sel);
        case (sel)
            3'd1:    poly_msb = 5'd8;
            3'd2:    poly_msb = 5'd14;
            3'd3:    poly_msb = 5'd22;
            3'd4:    poly_msb = 5'd30;
            default: poly_msb = 5'd6;
        endcase
    endfunction

    function automatic logic [4:0] poly_tap(input logic [2:0] sel);
        case (sel)
            3'd1:    poly_tap = 5'd4;
            3'd2:    poly_tap = 5'd13;
            3'd3:    poly_tap = 5'd17;
            3'd4:    poly_tap = 5'd27;
            default: poly_tap = 5'd5;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Configuration field decode
    // ------------------------------------------------------------------
    logic       cfg_enable;
    logic       cfg_start;
    logic       cfg_cont;
    logic       cfg_invert;
    logic [2:0] cfg_poly;

    assign cfg_enable = bus.cfg_ctrl[0];
    assign cfg_start  = bus.cfg_ctrl[1];
    assign cfg_cont   = bus.cfg_ctrl[2];
    assign cfg_invert = bus.cfg_ctrl[3];
    assign cfg_poly   = bus.cfg_ctrl[6:4];

    // Reserved control bits and the seed MSB never reach the LFSR.
    logic unused_cfg;
    assign unused_cfg = ^{bus.cfg_ctrl[31:7], bus.cfg_seed[31]};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]           state_q,      state_d;
    logic                 start_prev_q, start_prev_d;
    logic [2:0]           poly_q,       poly_d;
    logic                 invert_q,     invert_d;
    logic                 cont_q,       cont_d;
    logic [31:0]          len_q,        len_d;
    logic [DIV_WIDTH-1:0] div_q,        div_d;
    logic [DIV_WIDTH-1:0] div_cnt_q,    div_cnt_d;
    logic [30:0]          lfsr_q,       lfsr_d;
    logic [31:0]          bit_count_q,  bit_count_d;
    logic                 prbs_bit_q,   prbs_bit_d;
    logic                 bit_strobe_q, bit_strobe_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 aborted_q,    aborted_d;
    // Set on the final strobe of a fixed-length run; the following cycle
    // moves RUN to DONE so no further step can occur even with div=0.
    logic                 finish_q,     finish_d;

    // ------------------------------------------------------------------
    // LFSR step and seed load values
    // ------------------------------------------------------------------
    logic [30:0] run_mask;
    logic [4:0]  run_msb;
    logic [4:0]  run_tap;
    logic        fb;
    logic [30:0] lfsr_step;

    assign run_mask  = poly_mask(poly_q);
    assign run_msb   = poly_msb(poly_q);
    assign run_tap   = poly_tap(poly_q);
    assign fb        = lfsr_q[run_msb] ^ lfsr_q[run_tap];
    // The mask drops the bit shifted past position N-1.
    assign lfsr_step = {lfsr_q[29:0], fb} & run_mask;

    logic [30:0] load_mask;
    logic [30:0] seed_masked;
    logic [30:0] seed_load;

    assign load_mask   = poly_mask(cfg_poly);
    assign seed_masked = bus.cfg_seed[30:0] & load_mask;
    // An all-zero LFSR would lock up, so a zero seed becomes all-ones.
    assign seed_load   = (seed_masked == 31'd0) ? load_mask : seed_masked;

    logic        start_det;
    logic        div_hit;
    logic        last_bit;
    logic [31:0] bit_count_inc;

    assign start_det     = cfg_start & ~start_prev_q & cfg_enable;
    assign div_hit       = (div_cnt_q == div_q);
    assign bit_count_inc = bit_count_q + 32'd1;
    assign last_bit      = ~cont_q & (bit_count_inc == len_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        start_prev_d = cfg_start;
        poly_d       = poly_q;
        invert_d     = invert_q;
        cont_d       = cont_q;
        len_d        = len_q;
        div_d        = div_q;
        div_cnt_d    = div_cnt_q;
        lfsr_d       = lfsr_q;
        bit_count_d  = bit_count_q;
        prbs_bit_d   = prbs_bit_q;
        bit_strobe_d = 1'b0;
        busy_d       = (state_q == ST_LOAD) || (state_q == ST_RUN);
        done_d       = done_q;
        aborted_d    = aborted_q;
        finish_d     = finish_q;

        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!cfg_enable) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                    done_d    = 1'b0;
                end else begin
                    poly_d      = cfg_poly;
                    invert_d    = cfg_invert;
                    cont_d      = cfg_cont;
                    len_d       = bus.cfg_len;
                    div_d       = bus.cfg_div;
                    lfsr_d      = seed_load;
                    bit_count_d = 32'd0;
                    div_cnt_d   = '0;
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    finish_d    = 1'b0;
                    if ((bus.cfg_len == 32'd0) && !cfg_cont) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!cfg_enable) begin
                    // Abort: stream bit and count keep their last values.
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                    done_d    = 1'b0;
                end else if (finish_q) begin
                    state_d = ST_DONE;
                end else if (div_hit) begin
                    lfsr_d       = lfsr_step;
                    prbs_bit_d   = fb ^ invert_q;
                    bit_strobe_d = 1'b1;
                    bit_count_d  = bit_count_inc;   // wraps naturally
                    div_cnt_d    = '0;
                    if (last_bit) begin
                        finish_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end

            default: begin  // ST_DONE
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            poly_q       <= 3'd0;
            invert_q     <= 1'b0;
            cont_q       <= 1'b0;
            len_q        <= 32'd0;
            div_q        <= '0;
            div_cnt_q    <= '0;
            lfsr_q       <= 31'd0;
            bit_count_q  <= 32'd0;
            prbs_bit_q   <= 1'b0;
            bit_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            poly_q       <= poly_d;
            invert_q     <= invert_d;
            cont_q       <= cont_d;
            len_q        <= len_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            lfsr_q       <= lfsr_d;
            bit_count_q  <= bit_count_d;
            prbs_bit_q   <= prbs_bit_d;
            bit_strobe_q <= bit_strobe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            finish_q     <= finish_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.prbs_bit   = prbs_bit_q;
    assign bus.bit_strobe = bit_strobe_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bit_count  = bit_count_q;
    assign bus.status     = {25'd0, poly_q, 1'b0, aborted_q, done_q, busy_q};

endmodule

// File: tb/tb_prbs_stream_gen.sv
// ----------------------------------------------------------------------------
// tb_prbs_stream_gen
//
// Directed bench for prbs_stream_gen. Phase n means "1 ns after clock edge n",
// where edge 0 is the edge that samples the start condition.
// ----------------------------------------------------------------------------
module tb_prbs_stream_gen;

    localparam int DIV_WIDTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prbs_stream_gen_if #(.DIV_WIDTH(DIV_WIDTH)) bus_if ();

    prbs_stream_gen #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Capture results, one bit per phase 1..n
    logic [31:0] strobe_mask;
    logic [31:0] busy_mask;
    logic [31:0] done_mask;
    logic [31:0] bits_seen;
    logic [31:0] lfsr_at1;
    int          nstrobe;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] ctrl, input logic [31:0] seed,
                           input logic [31:0] len,  input logic [15:0] div);
        bus_if.cfg_ctrl = ctrl & ~32'h2;
        bus_if.cfg_seed = seed;
        bus_if.cfg_len  = len;
        bus_if.cfg_div  = div;
    endtask

    // Ends at phase 0 (just after the edge that samples start).
    task automatic launch();
        bus_if.cfg_ctrl[1] = 1'b0;
        tick();
        bus_if.cfg_ctrl[1] = 1'b1;
        tick();
    endtask

    // Records phases 1..n; optionally rewrites cfg_div after phase chg_at.
    task automatic capture(input int n, input int chg_at, input logic [15:0] chg_div);
        strobe_mask = '0;
        busy_mask   = '0;
        done_mask   = '0;
        bits_seen   = '0;
        lfsr_at1    = '0;
        nstrobe     = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == 1) lfsr_at1 = 32'(dut.lfsr_q);
            if (bus_if.bit_strobe) begin
                strobe_mask[i] = 1'b1;
                bits_seen      = {bits_seen[30:0], bus_if.prbs_bit};
                nstrobe++;
            end
            busy_mask[i] = bus_if.busy;
            done_mask[i] = bus_if.done;
            if (i == chg_at) bus_if.cfg_div = chg_div;
        end
    endtask

    initial begin
        logic [127:0] seen;
        int           repeats;
        int           missed;
        int           late;

        set_cfg(32'h0, 32'h0, 32'h0, 16'h0);
        bus_if.cfg_ctrl = 32'h0;

        // ---- reset state ----
        tick(); tick(); tick();
        check_val("rst_bits", 32'({bus_if.prbs_bit, bus_if.bit_strobe, bus_if.busy, bus_if.done}), 32'h0);
        check_val("rst_count", bus_if.bit_count, 32'h0);
        check_val("rst_status", bus_if.status, 32'h0);
        check_val("rst_lfsr", 32'(dut.lfsr_q), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- PRBS7 seed 1, div 0, len 10 ----
        set_cfg(32'h1, 32'h01, 32'd10, 16'd0);
        launch();
        capture(16, 0, 16'd0);
        check_val("p7_strobes", strobe_mask, 32'h0000_0FFC);
        check_val("p7_bits", bits_seen & 32'h3FF, 32'h0000_0018);
        check_val("p7_busy", busy_mask, 32'h0000_1FFE);
        check_val("p7_done", done_mask, 32'h0001_E000);
        check_val("p7_count", bus_if.bit_count, 32'd10);
        check_val("p7_status", bus_if.status, 32'h0000_0002);

        // ---- div 3, len 4 timing ----
        set_cfg(32'h1, 32'h01, 32'd4, 16'd3);
        launch();
        capture(31, 0, 16'd0);
        check_val("d3_strobes", strobe_mask, 32'h0002_2220);
        check_val("d3_busy", busy_mask, 32'h0007_FFFE);
        check_val("d3_done", done_mask, 32'hFFF8_0000);
        check_val("d3_count", bus_if.bit_count, 32'd4);

        // ---- PRBS7 continuous, seed 0x5A: full period ----
        set_cfg(32'h5, 32'h5A, 32'd0, 16'd0);
        launch();
        tick();
        check_val("c7_load", 32'(dut.lfsr_q), 32'h5A);
        seen = '0;
        seen[7'h5A] = 1'b1;
        repeats = 0;
        missed  = 0;
        for (int i = 1; i <= 127; i++) begin
            tick();
            if (!bus_if.bit_strobe) missed++;
            if (i < 127) begin
                if (seen[dut.lfsr_q[6:0]]) repeats++;
                seen[dut.lfsr_q[6:0]] = 1'b1;
            end
        end
        check_val("c7_period", 32'(dut.lfsr_q), 32'h5A);
        check_val("c7_repeats", 32'(repeats), 32'd0);
        check_val("c7_missed", 32'(missed), 32'd0);
        check_val("c7_count", bus_if.bit_count, 32'd127);
        bus_if.cfg_ctrl[0] = 1'b0;
        tick();
        check_val("c7_abort_flags", bus_if.status & 32'h6, 32'h4);
        tick(); tick();

        // ---- PRBS15 zero seed ----
        set_cfg(32'h21, 32'h0, 32'd15, 16'd0);
        launch();
        capture(20, 0, 16'd0);
        check_val("p15_load", lfsr_at1, 32'h7FFF);
        check_val("p15_bits", bits_seen & 32'h7FFF, 32'h0000_0001);
        check_val("p15_nstrobe", 32'(nstrobe), 32'd15);

        // ---- invert, poly select 5 (PRBS7) ----
        set_cfg(32'h59, 32'h01, 32'd7, 16'd0);
        launch();
        capture(12, 0, 16'd0);
        check_val("inv_bits", bits_seen & 32'h7F, 32'h0000_007C);
        check_val("inv_status", bus_if.status, 32'h0000_0052);

        // ---- abort after two strobes ----
        set_cfg(32'h1, 32'h01, 32'd20, 16'd3);
        launch();
        capture(9, 0, 16'd0);
        check_val("ab_nstrobe", 32'(nstrobe), 32'd2);
        bus_if.cfg_ctrl[0] = 1'b0;
        tick();
        check_val("ab_state", 32'(dut.state_q), 32'd0);
        check_val("ab_flags", bus_if.status & 32'h6, 32'h4);
        check_val("ab_count", bus_if.bit_count, 32'd2);
        late = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.bit_strobe) late++;
        end
        check_val("ab_late_strobes", 32'(late), 32'd0);
        check_val("ab_busy", 32'(bus_if.busy), 32'd0);

        // ---- zero length, non-continuous ----
        set_cfg(32'h1, 32'h01, 32'd0, 16'd0);
        launch();
        capture(6, 0, 16'd0);
        check_val("z_nstrobe", 32'(nstrobe), 32'd0);
        check_val("z_done", done_mask, 32'h0000_007C);
        check_val("z_status", bus_if.status, 32'h0000_0002);

        // ---- cfg_div change mid-run is ignored ----
        set_cfg(32'h1, 32'h01, 32'd4, 16'd1);
        launch();
        capture(14, 3, 16'd0);
        check_val("iso_strobes", strobe_mask, 32'h0000_02A8);

        // ---- asynchronous reset mid-run ----
        set_cfg(32'h5, 32'h01, 32'd0, 16'd0);
        launch();
        for (int i = 0; i < 6; i++) tick();
        check_val("ar_pre_busy", 32'(bus_if.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_bits", 32'({bus_if.prbs_bit, bus_if.bit_strobe, bus_if.busy, bus_if.done}), 32'h0);
        check_val("ar_count", bus_if.bit_count, 32'h0);
        check_val("ar_status", bus_if.status, 32'h0);
        late = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.bit_strobe) late++;
        end
        check_val("ar_strobes", 32'(late), 32'd0);
        bus_if.cfg_ctrl = 32'h0;
        rst_n = 1'b1;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
